// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus arbiter slice.
//   arb_state_e : arbiter FSM state codes, also driven out as the HEX display code
//   MAX_MASTERS : upper bound on the number of requesting masters
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_GRANT   = 3'd1,
        ARB_RELEASE = 3'd2,
        ARB_TIMEOUT = 3'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational priority picker. Searches the eligible vector starting at
// ptr_i and wrapping modulo N_MASTERS; the first set bit wins. Driving
// ptr_i = 0 gives plain fixed priority (lowest index wins).
// Ports:
//   eligible_i : candidate masters
//   ptr_i      : search start index (must be < N_MASTERS)
//   winner_o   : one-hot winner, zero when nothing is eligible
//   idx_o      : winner index, zero when nothing is eligible
//   found_o    : at least one master is eligible
// -----------------------------------------------------------------------------
module rr_pick
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int IDW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] eligible_i,
    input  logic [IDW-1:0]       ptr_i,
    output logic [N_MASTERS-1:0] winner_o,
    output logic [IDW-1:0]       idx_o,
    output logic                 found_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDW:0] cand;

    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, ptr_i} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_MASTERS)) begin
                cand = cand - (IDW+1)'(N_MASTERS);
            end
            if (!found_o && eligible_i[cand[IDW-1:0]]) begin
                found_o                   = 1'b1;
                idx_o                     = cand[IDW-1:0];
                winner_o[cand[IDW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// N-master bus arbiter with fixed-priority / round-robin selection, a
// registered one-hot grant, hold-timeout revocation and optional split parking.
//
// Optional feature macro: ARB_SPLIT_EN
//   defined   : split parks the current owner, split_release unparks masters
//   undefined : split / split_release ignored, split_mask reads 0
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   req            per-master level request
//   rr_mode        0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   split          slave defers current owner (pulse)
//   split_release  per-master unpark pulse
//   grant          registered one-hot grant (or zero)
//   bus_busy       |grant
//   owner_id       current or most recent owner index
//   timeout_pulse  one-cycle pulse after a forced revocation
//   split_mask     parked masters
//   arbiter_state  encoded FSM state
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrate among eligible masters, grant on the next edge
// GRANT   | owner holds the bus, hold counter running
// RELEASE | one zero-grant turnaround cycle after a normal/split release
// TIMEOUT | zero-grant cycle after forced revocation, timeout_pulse high
// -----------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 64,
    parameter int IDW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 rr_mode,
    input  logic                 split,
    input  logic [N_MASTERS-1:0] split_release,
    output logic [N_MASTERS-1:0] grant,
    output logic                 bus_busy,
    output logic [IDW-1:0]       owner_id,
    output logic                 timeout_pulse,
    output logic [N_MASTERS-1:0] split_mask,
    output logic [2:0]           arbiter_state
);

    if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || MAX_HOLD < 2) begin : g_bad_param
        $error("bus_arbiter_rr: N_MASTERS must be 2..MAX_MASTERS and MAX_HOLD >= 2");
    end

    localparam int             HCW       = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    arb_state_e             state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [HCW-1:0]         hold_q, hold_d;
    logic [N_MASTERS-1:0]   to_mask_q, to_mask_d;
    logic [N_MASTERS-1:0]   split_q, split_d;

    logic [N_MASTERS-1:0]   to_set, split_set;
    logic                   split_hit;
    logic [N_MASTERS-1:0]   split_clr;

`ifdef ARB_SPLIT_EN
    assign split_hit = split;
    assign split_clr = split_release;
`else
    assign split_hit = 1'b0;
    assign split_clr = '0;
    logic unused_split_in;
    assign unused_split_in = ^{split, split_release};
`endif

    logic [N_MASTERS-1:0]   eligible;
    logic [IDW-1:0]         pick_ptr;
    logic [N_MASTERS-1:0]   pick_onehot;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_found;

    assign eligible = req & ~split_q & ~to_mask_q;
    // Fixed priority is round-robin search anchored at index 0.
    assign pick_ptr = rr_mode ? ptr_q : '0;

    rr_pick #(
        .N_MASTERS (N_MASTERS),
        .IDW       (IDW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (pick_ptr),
        .winner_o   (pick_onehot),
        .idx_o      (pick_idx),
        .found_o    (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        to_set    = '0;
        split_set = '0;

        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    ptr_d   = (pick_idx == IDW'(N_MASTERS - 1)) ? '0 : pick_idx + IDW'(1);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hold_q != {HCW{1'b1}}) begin
                    hold_d = hold_q + HCW'(1);
                end
                if (!req[owner_q]) begin
                    grant_d = '0;
                    state_d = ARB_RELEASE;
                end else if (split_hit) begin
                    split_set[owner_q] = 1'b1;
                    grant_d            = '0;
                    state_d            = ARB_RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    to_set[owner_q] = 1'b1;
                    grant_d         = '0;
                    state_d         = ARB_TIMEOUT;
                end
            end
            ARB_RELEASE, ARB_TIMEOUT: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase

        // A timed-out master must be seen with req low before it can compete again.
        to_mask_d = (to_mask_q & req) | to_set;
        // Set wins over a same-cycle release of the same bit.
        split_d   = (split_q & ~split_clr) | split_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            to_mask_q <= '0;
            split_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            to_mask_q <= to_mask_d;
            split_q   <= split_d;
        end
    end

    assign grant         = grant_q;
    assign bus_busy      = |grant_q;
    assign owner_id      = owner_q;
    assign timeout_pulse = (state_q == ARB_TIMEOUT);
    assign split_mask    = split_q;
    assign arbiter_state = state_q;

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-master bus arbiter, the successor to the fixed two-master arbiter in the serial bus top level. It grants one master at a time with a registered one-hot grant and supports two modes: fixed-priority and round-robin. A hold-timeout revokes a grant that runs too long, and an optional split mechanism parks masters that a slave has deferred. It exposes a 3-bit state code so the board wrapper can drive a HEX digit.

## Interface
Parameters:
- N_MASTERS, 2: number of requesting masters (2..8).
- MAX_HOLD, 64: maximum consecutive cycles a grant may be held (≥2).
- IDW, $clog2(N_MASTERS) (min 1): owner index width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on clk.
- req  in  N_MASTERS  per-master request, level; held high for the whole transaction.
- rr_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- split  in  1  slave defers the current owner's transaction (pulse).
- split_release  in  N_MASTERS  per-master pulse that clears that master's split park.
- grant  out  N_MASTERS  one-hot or zero, registered.
- bus_busy  out  1  high whenever grant != 0.
- owner_id  out  IDW  index of current or last owner.
- timeout_pulse  out  1  one-cycle pulse on forced revocation.
- split_mask  out  N_MASTERS  parked masters (0 when split compiled out).
- arbiter_state  out  3  encoded FSM state.

## Operation
- States: IDLE=3'd0, GRANT=3'd1, RELEASE=3'd2, TIMEOUT=3'd3.
- Eligible set = req & ~split_mask & ~to_mask.
- IDLE: if the eligible set is non-empty, pick a winner, load grant one-hot, owner_id=winner, clear hold_cnt, then go to GRANT. Otherwise stay in IDLE with grant=0.
- Fixed priority picks the lowest eligible index.
- Round-robin picks the first eligible index at or after ptr, wrapping modulo N_MASTERS. On each grant ptr ← (winner+1) mod N_MASTERS.
- rr_mode is sampled only in IDLE. A change mid-grant takes effect at the next arbitration.
- GRANT: hold_cnt increments every cycle, saturating. Exits in priority order:
  - req[owner]=0 → RELEASE.
  - split=1 → set split_mask[owner], then RELEASE.
  - hold_cnt == MAX_HOLD-1 → set to_mask[owner], then TIMEOUT.
- RELEASE: grant=0 for exactly one turnaround cycle, then IDLE.
- TIMEOUT: grant=0, timeout_pulse=1 for this one cycle, then IDLE.
- to_mask[i] clears when req[i] is seen low, so a timed-out master must drop and re-raise its request.
- split_release[i] clears split_mask[i]. If a set and a clear hit the same bit in the same cycle, the set wins.
- Reset values: grant=0, bus_busy=0, owner_id=0, ptr=0, split_mask=0, to_mask=0, hold_cnt=0, timeout_pulse=0, state=IDLE.
- Reset asserted mid-grant drops grant on that edge; no RELEASE cycle is generated.

## Timing
- Grant latency: req sampled high in IDLE → grant high on the next edge (1 cycle).
- Back-to-back grants are separated by at least one zero-grant cycle (RELEASE or TIMEOUT).
- Minimum cycle from one grant to the next is 3: GRANT, RELEASE, IDLE.
- Maximum continuous grant is MAX_HOLD cycles.
- bus_busy is combinational from the grant register: bus_busy = |grant.
- owner_id keeps its value after release, for display.

## Configuration
- ARB_SPLIT_EN defined: split, split_release and split_mask behave as described above.
- ARB_SPLIT_EN undefined: split and split_release are ignored, split_mask is tied to 0, and the split exit from GRANT does not exist.

## Structure
- Shared package bus_pkg holds:
  - the state enum codes (ARB_IDLE, ARB_GRANT, ARB_RELEASE, ARB_TIMEOUT);
  - MAX_MASTERS=8.
- Sub-module rr_pick: combinational priority picker with inputs eligible and ptr (ptr forced to 0 in fixed mode). It outputs a one-hot winner and its index.

## Test plan
- N=2, fixed mode, req=2'b11 at reset release → grant=2'b01 one cycle later. Drop req[0] → RELEASE, IDLE, then grant=2'b10 at the third edge after the drop.
- N=4, rr_mode=1, req=4'b1111 held, each master drops req after 3 grant cycles → grants in order 0,1,2,3,0.
- MAX_HOLD=8, master 1 holds req for 20 cycles → grant ends after 8 cycles, timeout_pulse for 1 cycle. Master 1 is not re-granted until req[1] toggles 1→0→1.
- ARB_SPLIT_EN, N=3, split pulse while master 0 is granted → split_mask=3'b001 and master 2 is granted. split_release=3'b001 → master 0 is eligible again.
- Same-cycle req[owner] drop and split → RELEASE with split_mask unchanged.
- Reset asserted during GRANT → grant=0, arbiter_state=0 and ptr=0 on the same edge. A request on the following cycle is granted normally.
